bnn_uart_tx: RTL and testbench

UART transmitter with hardware flow control that carries result bytes from the BNN controller back to the host. The controller pushes bytes through a valid/ready port into a small internal FIFO. The block serialises each byte as 8N1 on `uart_tx`, starting a frame only while the host asserts its ready-to-receive line. It is the transmit-side counterpart of the controller's UART receive path and sits between the controller and the top-level `uo_out` pin.

---
 rtl/bnn_uart_tx.sv | 154 +++++++++++++++
 tb/tb_bnn_uart_tx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : bnn_uart_tx
// Brief    : 8N1 UART transmitter with a small byte FIFO and host RTS gating.
// Revision : 1.0 - initial release
// ============================================================================
module bnn_uart_tx #(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       host_rts,
    output logic       uart_tx,
    output logic       busy,
    output logic       frame_done
);

    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [c_PTR_W:0]    c_FULL      = (c_PTR_W+1)'(FIFO_DEPTH);
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BAUD_W-1:0] c_BAUD_PRE  = c_BAUD_W'(CLKS_PER_BIT - 2);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_PTR_W:0]    r_count;
    logic                r_rts_m;
    logic                r_rts_s;
    logic [1:0]          r_state;
    logic [c_BAUD_W-1:0] r_baud;
    logic [2:0]          r_bit_idx;
    logic [7:0]          r_shift;
    logic                r_uart_tx;
    logic                r_frame_done;
    logic                w_push;
    logic                w_pop;

    assign tx_ready   = (r_count != c_FULL);
    assign w_push     = tx_valid & tx_ready;
    assign w_pop      = (r_state == S_IDLE) & (r_count != '0) & r_rts_s;
    assign busy       = (r_state != S_IDLE) | (r_count != '0);
    assign uart_tx    = r_uart_tx;
    assign frame_done = r_frame_done;

    // host_rts is asynchronous to clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rts_m <= 1'b0;
            r_rts_s <= 1'b0;
        end else begin
            r_rts_m <= host_rts;
            r_rts_s <= r_rts_m;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_baud       <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_uart_tx    <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_baud <= '0;
                    if (w_pop) begin
                        r_shift   <= r_mem[r_rd_ptr];
                        r_uart_tx <= 1'b0;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    if (r_baud == c_BAUD_LAST) begin
                        r_baud    <= '0;
                        r_uart_tx <= r_shift[0];
                        r_bit_idx <= 3'd0;
                        r_state   <= S_DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_baud == c_BAUD_LAST) begin
                        r_baud <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_uart_tx <= 1'b1;
                            r_state   <= S_STOP;
                        end else begin
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_uart_tx <= r_shift[1];
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_baud == c_BAUD_LAST) begin
                        r_baud  <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                        // registered one cycle early so the pulse lands on the final stop cycle
                        if (r_baud == c_BAUD_PRE) begin
                            r_frame_done <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bnn_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_bnn_uart_tx
// Brief    : Directed self-checking bench for bnn_uart_tx (4 clocks per bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bnn_uart_tx;

    localparam int c_CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       host_rts;
    logic       uart_tx;
    logic       busy;
    logic       frame_done;

    int n_cmp = 0;
    int n_err = 0;

    bnn_uart_tx #(
        .CLKS_PER_BIT(c_CPB),
        .FIFO_DEPTH  (4)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .host_rts  (host_rts),
        .uart_tx   (uart_tx),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic push(input logic [7:0] b, output logic acc);
        tx_data  = b;
        tx_valid = 1'b1;
        acc      = tx_ready;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Finds the start bit, then checks all 40 line cycles and the frame_done position.
    task automatic rx_frame(input string tag, input logic [7:0] exp,
                            output int waits, output logic rdy0);
        int bad, fd_cnt, fd_pos, b;
        logic [7:0] d;
        logic ebit;
        waits = 0;
        while (uart_tx !== 1'b0 && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        rdy0 = tx_ready;
        if (uart_tx !== 1'b0) begin
            check({tag, " start"}, {31'd0, uart_tx}, 32'd0);
            return;
        end
        bad = 0; fd_cnt = 0; fd_pos = -1; d = 8'h00;
        for (int c = 0; c < 10 * c_CPB; c++) begin
            if (c > 0) @(negedge clk);
            b = c / c_CPB;
            ebit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : exp[b-1];
            if (uart_tx !== ebit) bad++;
            if (b >= 1 && b <= 8 && (c % c_CPB) == 2) d[b-1] = uart_tx;
            if (frame_done === 1'b1) begin
                fd_cnt++;
                fd_pos = c;
            end
        end
        check({tag, " bad cycles"}, bad, 0);
        check({tag, " byte"}, {24'd0, d}, {24'd0, exp});
        check({tag, " done count"}, fd_cnt, 1);
        check({tag, " done pos"}, fd_pos, 10 * c_CPB - 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " uart_tx"}, {31'd0, uart_tx}, 32'd1);
        check({tag, " busy"}, {31'd0, busy}, 32'd0);
        check({tag, " frame_done"}, {31'd0, frame_done}, 32'd0);
        check({tag, " tx_ready"}, {31'd0, tx_ready}, 32'd1);
    endtask

    int   w, w4, lows, busys, k;
    logic acc, r, r4;

    initial begin
        rst_n    = 1'b0;
        host_rts = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;

        // Reset values while asserted and on the first cycle after release
        @(negedge clk);
        check_reset_outputs("rst held");
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst released");
        repeat (3) @(negedge clk);

        // Single byte
        push(8'hA5, acc);
        check("t1 accept", {31'd0, acc}, 32'd1);
        check("t1 line high at E0", {31'd0, uart_tx}, 32'd1);
        check("t1 busy queued", {31'd0, busy}, 32'd1);
        rx_frame("t1 A5", 8'hA5, w, r);
        check("t1 push latency", w, 1);
        check("t1 busy in stop", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("t1 busy after", {31'd0, busy}, 32'd0);
        check("t1 line idle", {31'd0, uart_tx}, 32'd1);

        // Fill the FIFO with RTS low
        host_rts = 1'b0;
        repeat (3) @(negedge clk);
        push(8'h01, acc); check("t2 acc 01", {31'd0, acc}, 32'd1);
        push(8'h02, acc); check("t2 acc 02", {31'd0, acc}, 32'd1);
        push(8'h03, acc); check("t2 acc 03", {31'd0, acc}, 32'd1);
        check("t2 ready at 3", {31'd0, tx_ready}, 32'd1);
        push(8'h04, acc); check("t2 acc 04", {31'd0, acc}, 32'd1);
        check("t2 ready full", {31'd0, tx_ready}, 32'd0);
        push(8'h05, acc); check("t2 acc 05", {31'd0, acc}, 32'd0);
        check("t2 line held", {31'd0, uart_tx}, 32'd1);
        host_rts = 1'b1;
        rx_frame("t2 01", 8'h01, w, r);
        check("t2 rts latency", w, 3);
        check("t2 ready after pop", {31'd0, r}, 32'd1);
        rx_frame("t2 02", 8'h02, w, r); check("t2 gap 02", w, 2);
        rx_frame("t2 03", 8'h03, w, r); check("t2 gap 03", w, 2);
        rx_frame("t2 04", 8'h04, w, r); check("t2 gap 04", w, 2);
        repeat (2) @(negedge clk);

        // RTS drop mid-frame
        push(8'h3C, acc);
        push(8'h55, acc);
        check("t3 acc 55", {31'd0, acc}, 32'd1);
        fork
            rx_frame("t3 3C", 8'h3C, w, r);
            begin
                repeat (12) @(negedge clk);
                host_rts = 1'b0;
            end
        join
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
        end
        check("t3 held while rts low", lows, 0);
        check("t3 busy queued", {31'd0, busy}, 32'd1);
        host_rts = 1'b1;
        rx_frame("t3 55", 8'h55, w, r);
        check("t3 rts latency", w, 3);

        // Full FIFO: pop at IDLE->START then push on the next cycle
        host_rts = 1'b0;
        repeat (3) @(negedge clk);
        push(8'h11, acc);
        push(8'h22, acc);
        push(8'h33, acc);
        push(8'h44, acc);
        check("t4 full", {31'd0, tx_ready}, 32'd0);
        host_rts = 1'b1;
        fork
            rx_frame("t4 11", 8'h11, w4, r4);
            begin
                k = 0;
                while (uart_tx !== 1'b0 && k < 200) begin
                    @(negedge clk);
                    k++;
                end
                push(8'h99, acc);
                check("t4 acc 99", {31'd0, acc}, 32'd1);
                check("t4 full again", {31'd0, tx_ready}, 32'd0);
            end
        join
        check("t4 ready at pop", {31'd0, r4}, 32'd1);
        rx_frame("t4 22", 8'h22, w, r); check("t4 gap 22", w, 2);
        rx_frame("t4 33", 8'h33, w, r); check("t4 gap 33", w, 2);
        rx_frame("t4 44", 8'h44, w, r); check("t4 gap 44", w, 2);
        rx_frame("t4 99", 8'h99, w, r); check("t4 gap 99", w, 2);
        repeat (2) @(negedge clk);

        // Async reset during bit 3 of 0xFF with two bytes queued
        host_rts = 1'b0;
        repeat (3) @(negedge clk);
        push(8'hFF, acc);
        push(8'h12, acc);
        push(8'h34, acc);
        host_rts = 1'b1;
        k = 0;
        while (uart_tx !== 1'b0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("t5 start", {31'd0, uart_tx}, 32'd0);
        repeat (4 * c_CPB - 2) @(negedge clk);
        check("t5 busy before", {31'd0, busy}, 32'd1);
        check("t5 full-ish", {31'd0, tx_ready}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("t5 async rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        lows = 0; busys = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
            if (busy !== 1'b0) busys++;
        end
        check("t5 no frame after rst", lows, 0);
        check("t5 idle after rst", busys, 0);
        push(8'h5A, acc);
        rx_frame("t5 5A", 8'h5A, w, r);
        check("t5 push latency", w, 1);

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
